// File: rtl/pattern_scan_pkg.sv
// Shared constants for the pattern scan controller: default widths and FSM state encoding.
package pattern_scan_pkg;

  localparam int unsigned PS_SYM_W   = 2;
  localparam int unsigned PS_MAX_LEN = 4;
  localparam int unsigned PS_CNT_W   = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SCAN = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/pattern_scan_match.sv
// Combinational symbol compare and next-progress unit for the pattern scanner.
// PATTERN_SCAN_OVERLAP_EN lets the completing symbol start the next match.
module pattern_scan_match #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned MAX_LEN = 4,
  localparam int unsigned IDX_W  = $clog2(MAX_LEN),
  localparam int unsigned LEN_W  = IDX_W + 1
) (
  input  logic [MAX_LEN-1:0][SYM_W-1:0] pat,
  input  logic [LEN_W-1:0]              len,
  input  logic [IDX_W-1:0]              progress,
  input  logic [SYM_W-1:0]              sym,
  output logic [IDX_W-1:0]              next_progress,
  output logic                          full_match
);

  logic             eq;
  logic             last;
  logic [IDX_W-1:0] restart;

  // Fallback: a symbol equal to the first pattern slot restarts at progress 1.
  always_comb begin
    eq            = (sym == pat[progress]);
    last          = (LEN_W'(progress) == (len - LEN_W'(1)));
    full_match    = eq && last;
    restart       = ((len > LEN_W'(1)) && (sym == pat[0])) ? IDX_W'(1) : '0;
    next_progress = restart;
    if (full_match) begin
`ifdef PATTERN_SCAN_OVERLAP_EN
      next_progress = restart;
`else
      next_progress = '0;
`endif
    end else if (eq) begin
      next_progress = progress + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Programmable 2-bit-symbol pattern scan controller: start/abort FSM, match counter, status.
// Build option PATTERN_SCAN_OVERLAP_EN selects overlapping match detection.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int unsigned SYM_W   = PS_SYM_W,
  parameter int unsigned MAX_LEN = PS_MAX_LEN,
  parameter int unsigned CNT_W   = PS_CNT_W,
  localparam int unsigned IDX_W  = $clog2(MAX_LEN),
  localparam int unsigned LEN_W  = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  logic [1:0]                     state_q, state_d;
  logic [MAX_LEN-1:0][SYM_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [CNT_W-1:0]               target_q, target_d;
  logic [IDX_W-1:0]               prog_q, prog_d;
  logic [CNT_W-1:0]               cnt_d;
  logic                           hit_d, err_d, busy_d, done_d;
  logic                           cfg_ok_c;
  logic [CNT_W-1:0]               cnt_inc_c;
  logic [IDX_W-1:0]               next_prog_c;
  logic                           full_match_c;

  pattern_scan_match #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .pat           (pat_q),
    .len           (len_q),
    .progress      (prog_q),
    .sym           (sym),
    .next_progress (next_prog_c),
    .full_match    (full_match_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      target_q  <= '0;
      prog_q    <= '0;
      match_cnt <= '0;
      hit       <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      target_q  <= target_d;
      prog_q    <= prog_d;
      match_cnt <= cnt_d;
      hit       <= hit_d;
      cfg_err   <= err_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and datapath update; abort outranks every other request
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    target_d  = target_q;
    prog_d    = prog_q;
    cnt_d     = match_cnt;
    hit_d     = 1'b0;
    err_d     = cfg_err;
    cfg_ok_c  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN)) && (cfg_target != '0);
    cnt_inc_c = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

    if (abort) begin
      state_d = ST_IDLE;
      prog_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_we && (state_q == ST_IDLE)) begin
            pat_d[cfg_idx] = cfg_sym;
          end
          if (start) begin
            if (cfg_ok_c) begin
              len_d    = cfg_len;
              target_d = cfg_target;
              cnt_d    = '0;
              err_d    = 1'b0;
              prog_d   = '0;
              state_d  = ST_SCAN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (sym_valid) begin
            prog_d = next_prog_c;
            if (full_match_c) begin
              hit_d = 1'b1;
              cnt_d = cnt_inc_c;
              if (cnt_inc_c == target_q) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          prog_d  = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed tables, corner sequences and a random run.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [1:0] cfg_sym;
  logic [2:0] cfg_len;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       sym_valid;
  logic [1:0] sym;
  logic       busy;
  logic       done;
  logic       hit;
  logic [7:0] match_cnt;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_sym    (cfg_sym),
    .cfg_len    (cfg_len),
    .cfg_target (cfg_target),
    .start      (start),
    .abort      (abort),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  // Reference model: mode 0 = idle, 1 = scanning, 2 = finished
  int m_mode;
  int m_pat[4];
  int m_len, m_tgt, m_prog, m_cnt;
  int m_hit, m_err;

  typedef struct {
    logic [1:0] s;
    logic       hit;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t t1[5];
  vec_t t2[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    foreach (m_pat[i]) m_pat[i] = 0;
    m_len = 0; m_tgt = 0; m_prog = 0; m_cnt = 0; m_hit = 0; m_err = 0;
  endfunction

  function automatic void model_try_start();
    int l, t;
    l = int'(cfg_len);
    t = int'(cfg_target);
    if (l >= 1 && l <= 4 && t != 0) begin
      m_len = l; m_tgt = t; m_cnt = 0; m_err = 0; m_prog = 0; m_mode = 1;
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic void model_step();
    int s, first_ok;
    m_hit = 0;
    s = int'(sym);
    if (abort) begin
      m_mode = 0;
      m_prog = 0;
    end else if (m_mode == 0) begin
      if (cfg_we) m_pat[int'(cfg_idx)] = int'(cfg_sym);
      if (start) model_try_start();
    end else if (m_mode == 2) begin
      if (start) model_try_start();
    end else if (sym_valid) begin
      first_ok = (m_len > 1 && s == m_pat[0]) ? 1 : 0;
      if (s == m_pat[m_prog] && m_prog == m_len - 1) begin
        m_hit = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        if (m_cnt == m_tgt) m_mode = 2;
`ifdef PATTERN_SCAN_OVERLAP_EN
        m_prog = first_ok;
`else
        m_prog = 0;
`endif
      end else if (s == m_pat[m_prog]) begin
        m_prog = m_prog + 1;
      end else begin
        m_prog = first_ok;
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(m_mode == 1));
    chk({tag, "_done"}, 32'(done), 32'(m_mode == 2));
    chk({tag, "_hit"}, 32'(hit), 32'(m_hit));
    chk({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
    chk({tag, "_err"}, 32'(cfg_err), 32'(m_err));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_idx = 0; cfg_sym = 0; cfg_len = 0; cfg_target = 0;
    start = 0; abort = 0; sym_valid = 0; sym = 0;
  endtask

  task automatic write_slot(input int idx, input logic [1:0] s);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_sym = s;
    cycle("wr");
    cfg_we = 0;
  endtask

  task automatic do_start(input int len, input int tgt);
    start = 1; cfg_len = 3'(len); cfg_target = 8'(tgt);
    cycle("start");
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    cycle("abort");
    abort = 0;
  endtask

  task automatic feed(input logic [1:0] s);
    sym_valid = 1; sym = s;
    cycle("feed");
    sym_valid = 0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    feed(v.s);
    chk({tag, "_hit"}, 32'(hit), 32'(v.hit));
    chk({tag, "_cnt"}, 32'(match_cnt), 32'(v.cnt));
    chk({tag, "_busy"}, 32'(busy), 32'(v.busy));
    chk({tag, "_done"}, 32'(done), 32'(v.done));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    t1[0] = '{2'b01, 1'b0, 8'd0, 1'b1, 1'b0};
    t1[1] = '{2'b10, 1'b0, 8'd0, 1'b1, 1'b0};
    t1[2] = '{2'b11, 1'b1, 8'd1, 1'b0, 1'b1};
    t1[3] = '{2'b00, 1'b0, 8'd1, 1'b0, 1'b1};
    t1[4] = '{2'b01, 1'b0, 8'd1, 1'b0, 1'b1};

    t2[0] = '{2'b01, 1'b0, 8'd0, 1'b1, 1'b0};
    t2[1] = '{2'b01, 1'b0, 8'd0, 1'b1, 1'b0};
    t2[2] = '{2'b10, 1'b0, 8'd0, 1'b1, 1'b0};
    t2[3] = '{2'b11, 1'b1, 8'd1, 1'b1, 1'b0};
    t2[4] = '{2'b00, 1'b0, 8'd1, 1'b1, 1'b0};
    t2[5] = '{2'b01, 1'b0, 8'd1, 1'b1, 1'b0};
    t2[6] = '{2'b10, 1'b0, 8'd1, 1'b1, 1'b0};
    t2[7] = '{2'b11, 1'b1, 8'd2, 1'b0, 1'b1};

    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    check_outputs("reset");
    rst_n = 1;

    // Plan 1: single match ends the scan, further symbols ignored
    write_slot(0, 2'b01);
    write_slot(1, 2'b10);
    write_slot(2, 2'b11);
    do_start(3, 1);
    chk("t1_start_busy", 32'(busy), 32'd1);
    foreach (t1[i]) run_vec("t1", t1[i]);

    // Plan 2: restart from DONE, target 2, fallback on repeated first symbol
    do_start(3, 2);
    foreach (t2[i]) run_vec("t2", t2[i]);

    // Plan 3: invalid starts flag cfg_err and stay idle
    do_abort();
    do_start(0, 1);
    chk("t3_len0_err", 32'(cfg_err), 32'd1);
    chk("t3_len0_busy", 32'(busy), 32'd0);
    do_start(5, 1);
    chk("t3_len5_err", 32'(cfg_err), 32'd1);
    chk("t3_len5_busy", 32'(busy), 32'd0);
    do_start(3, 0);
    chk("t3_tgt0_err", 32'(cfg_err), 32'd1);
    do_start(3, 1);
    chk("t3_valid_err", 32'(cfg_err), 32'd0);
    chk("t3_valid_busy", 32'(busy), 32'd1);
    do_abort();

    // Plan 4: overlapping vs non-overlapping matches
    write_slot(0, 2'b01);
    write_slot(1, 2'b01);
    do_start(2, 3);
    feed(2'b01);
    feed(2'b01);
    feed(2'b01);
`ifdef PATTERN_SCAN_OVERLAP_EN
    chk("t4_cnt", 32'(match_cnt), 32'd2);
`else
    chk("t4_cnt", 32'(match_cnt), 32'd1);
`endif
    do_abort();

    // Plan 5: abort with start mid-scan, cfg_we during scan ignored
    write_slot(1, 2'b10);
    write_slot(2, 2'b11);
    do_start(3, 2);
    feed(2'b01);
    feed(2'b10);
    feed(2'b11);
    cfg_we = 1; cfg_idx = 2'd0; cfg_sym = 2'b11;
    cycle("t5_we");
    cfg_we = 0;
    feed(2'b01);
    feed(2'b10);
    abort = 1; start = 1; cfg_len = 3'd3; cfg_target = 8'd1;
    cycle("t5_abort");
    abort = 0; start = 0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_hit", 32'(hit), 32'd0);
    chk("t5_cnt_held", 32'(match_cnt), 32'd1);
    do_start(3, 1);
    feed(2'b01);
    feed(2'b10);
    feed(2'b11);
    chk("t5_rescan_hit", 32'(hit), 32'd1);
    chk("t5_rescan_done", 32'(done), 32'd1);

    // Plan 6: asynchronous reset mid-scan clears pattern and outputs
    do_start(3, 1);
    feed(2'b01);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt", 32'(match_cnt), 32'd0);
    check_outputs("t6_rst");
    #2;
    rst_n = 1;
    do_start(1, 1);
    feed(2'b00);
    chk("t6_zero_hit", 32'(hit), 32'd1);
    chk("t6_zero_cnt", 32'(match_cnt), 32'd1);
    chk("t6_zero_done", 32'(done), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      abort      = ($urandom % 40) == 0;
      start      = ($urandom % 8) == 0;
      cfg_we     = ($urandom % 3) == 0;
      cfg_idx    = 2'($urandom);
      cfg_sym    = 2'($urandom);
      cfg_len    = 3'($urandom_range(0, 5));
      cfg_target = 8'($urandom_range(0, 3));
      sym_valid  = ($urandom % 4) != 0;
      sym        = 2'($urandom);
      cycle("rand");
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Programmable controller for the 2-bit-symbol sequence-detection datapath.
- Holds a configurable pattern of up to MAX_LEN symbols and sequences the scan through start/abort control.
- Counts matches and ends the scan when a target match count is reached.
- Sits between the control bus (configuration and start) and the symbol stream source; exposes busy/done/hit status to the upstream sequencer.

Parameters:
SYM_W, 2, symbol width in bits
MAX_LEN, 4, maximum pattern length in symbols (power of 2)
CNT_W, 8, width of match counter and target

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  pattern slot write strobe; honoured only in IDLE
cfg_idx  in  $clog2(MAX_LEN)  pattern slot index
cfg_sym  in  SYM_W  symbol written to slot cfg_idx
cfg_len  in  $clog2(MAX_LEN)+1  pattern length; sampled on start
cfg_target  in  CNT_W  matches required to finish; sampled on start
start  in  1  begin scan; honoured only in IDLE or DONE
abort  in  1  return to IDLE from any state; highest priority
sym_valid  in  1  sym carries a new symbol this cycle
sym  in  SYM_W  stream symbol
busy  out  1  high in SCAN
done  out  1  high in DONE
hit  out  1  one-cycle pulse per full pattern match
match_cnt  out  CNT_W  matches in the current scan
cfg_err  out  1  sticky: last start carried an invalid length or target

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; all outputs 0; progress pointer 0.
  - Pattern registers 0; latched len/target 0.
- States and transitions:
  - IDLE: cfg_we writes pat[cfg_idx] <= cfg_sym. On start:
    - If 1 <= cfg_len <= MAX_LEN and cfg_target != 0: latch len/target, clear match_cnt and cfg_err, go to SCAN.
    - Otherwise set cfg_err and stay in IDLE.
  - SCAN: on each sym_valid, compare sym against pat[progress]:
    - Equal and progress == len-1 (full match): next cycle hit=1, match_cnt+1, progress reset per the Optional Feature.
    - If the incremented match_cnt == target on a full match: go to DONE (same edge that registers the hit).
    - Equal, not last: progress+1.
    - Not equal: progress <= (sym == pat[0]) ? 1 : 0. When len == 1, a mismatch always gives 0.
    - sym_valid low: hold everything.
  - DONE: done=1; symbols ignored; match_cnt held. start (valid config) re-enters SCAN with the counter cleared. cfg_we is ignored in DONE.
- abort: any state -> IDLE next edge. Clears progress and hit; match_cnt is held for readout. abort has priority over start when both are asserted.
- Latency: hit and match_cnt update one cycle after the completing symbol is sampled.
- match_cnt saturates at all-ones; it cannot wrap before target, since target <= all-ones.
- cfg_we during SCAN/DONE: ignored, no side effect.
- Reset mid-scan: immediate IDLE; pattern registers lost.

Optional Feature:
- Macro: PATTERN_SCAN_OVERLAP_EN.
- Defined: after a full match, progress <= (len > 1 && sym == pat[0]) ? 1 : 0, so the last symbol may begin the next match.
- Undefined: after a full match, progress <= 0 (non-overlapping matches).

Decomposition:
- Shared package pattern_scan_pkg holds:
  - State encoding constants: IDLE=2'b00, SCAN=2'b01, DONE=2'b10.
  - Symbol width constant.
- One natural sub-module: pattern_scan_match, the combinational compare / next-progress unit. Inputs: pattern, len, progress, sym. Outputs: next_progress, full_match.
- FSM and counter stay in the top module.

Test Plan:
1. pat={01,10,11}, len=3, target=1, start; feed 01,10,11 -> hit pulse one cycle after the 11 is sampled, match_cnt=1, done=1, busy=0; further symbols leave match_cnt=1.
2. Same config, target=2; feed 01,01,10,11,00,01,10,11 -> two hit pulses, done after the second; the repeated 01 keeps progress at 1 (fallback rule).
3. cfg_len=0, then cfg_len=5, each with start -> cfg_err=1, state stays IDLE, busy=0; then a valid start -> cfg_err clears, busy=1.
4. pat={01,01}, len=2, target=3; feed 01,01,01 -> with PATTERN_SCAN_OVERLAP_EN: match_cnt=2; without it: match_cnt=1.
5. abort asserted mid-SCAN after 2 matched symbols, together with start -> IDLE next cycle, match_cnt held, hit=0. A cfg_we issued during SCAN leaves the pattern unchanged (check by rescanning).
6. rst_n low asynchronously between clock edges during SCAN -> all outputs 0 immediately; after release, state is IDLE and the pattern reads as zeros (len=1, target=1, feed 00 -> hit).
